// File: rtl/obi_dual_port_ram.sv
// Shared word-addressed RAM behind two independent OBI slave ports (instr, data).
// Zero wait states, one-cycle registered response, read-first, data port wins byte collisions.
module obi_dual_port_ram #(
    parameter int MEM_SIZE_WORD = 40960
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic        instr_we_i,
    input  logic [3:0]  instr_be_i,
    input  logic [31:0] instr_addr_i,
    input  logic [31:0] instr_wdata_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o
);
    localparam int AW = (MEM_SIZE_WORD > 1) ? $clog2(MEM_SIZE_WORD) : 1;
    localparam int NP = 2;

    logic [31:0] mem_array [0:MEM_SIZE_WORD-1];

    // Port 0 = instruction, port 1 = data; write order below makes port 1 win.
    logic [NP-1:0]          req, we, in_range, rvalid_q;
    logic [NP-1:0][3:0]     be;
    logic [NP-1:0][31:0]    addr, wdata, rdata_q;
    logic [NP-1:0][AW-1:0]  widx;
    logic                   unused_addr_lsb;

    assign req   = {data_req_i,   instr_req_i};
    assign we    = {data_we_i,    instr_we_i};
    assign be    = {data_be_i,    instr_be_i};
    assign addr  = {data_addr_i,  instr_addr_i};
    assign wdata = {data_wdata_i, instr_wdata_i};

    assign unused_addr_lsb = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    always_comb begin
        in_range = '0;
        widx     = '0;
        for (int p = 0; p < NP; p++) begin
            in_range[p] = ({2'b00, addr[p][31:2]} < 32'(MEM_SIZE_WORD));
            widx[p]     = addr[p][AW+1:2];
        end
    end

    // Array has no reset so preloaded contents survive; writes need rst_i low.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int p = 0; p < NP; p++) begin
                if (req[p] && we[p] && in_range[p]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[p][b])
                            mem_array[widx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

    // Response path samples the pre-write word (read-first) and holds it until the next response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                rvalid_q[p] <= req[p];
                if (req[p])
                    rdata_q[p] <= in_range[p] ? mem_array[widx[p]] : 32'h0;
            end
        end
    end

    assign instr_gnt_o    = instr_req_i;
    assign data_gnt_o     = data_req_i;
    assign instr_rvalid_o = rvalid_q[0];
    assign data_rvalid_o  = rvalid_q[1];
    assign instr_rdata_o  = rdata_q[0];
    assign data_rdata_o   = rdata_q[1];

endmodule

// File: tb/tb_obi_dual_port_ram.sv
// Randomised + directed bench for obi_dual_port_ram against a word-array reference model.
module tb_obi_dual_port_ram;
    localparam int MW = 40960;

    logic        clk, rst;
    logic        instr_req_i, instr_we_i, data_req_i, data_we_i;
    logic [3:0]  instr_be_i, data_be_i;
    logic [31:0] instr_addr_i, instr_wdata_i, data_addr_i, data_wdata_i;
    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [31:0] instr_rdata_o, data_rdata_o;

    obi_dual_port_ram #(.MEM_SIZE_WORD(MW)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req_i), .instr_we_i(instr_we_i), .instr_be_i(instr_be_i),
        .instr_addr_i(instr_addr_i), .instr_wdata_i(instr_wdata_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ref_mem [0:MW-1];
    logic [31:0] exp_rd [2];
    logic        exp_rv [2];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            instr_req_i = r; instr_we_i = w; instr_be_i = b; instr_addr_i = a; instr_wdata_i = d;
        end else begin
            data_req_i = r; data_we_i = w; data_be_i = b; data_addr_i = a; data_wdata_i = d;
        end
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // One bus cycle: inputs already driven after a negedge; model the edge, then check at the next negedge.
    task automatic step();
        logic [1:0]  r, w;
        logic [3:0]  b [2];
        logic [31:0] a [2], d [2];
        int wi;
        r = {data_req_i, instr_req_i};
        w = {data_we_i, instr_we_i};
        b[0] = instr_be_i; b[1] = data_be_i;
        a[0] = instr_addr_i; a[1] = data_addr_i;
        d[0] = instr_wdata_i; d[1] = data_wdata_i;
        #1;
        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, r[0]});
        chk("data_gnt",  {31'b0, data_gnt_o},  {31'b0, r[1]});
        for (int p = 0; p < 2; p++) begin
            wi = int'(a[p] >> 2);
            exp_rv[p] = r[p];
            if (r[p]) exp_rd[p] = (wi < MW) ? ref_mem[wi] : 32'h0;
        end
        for (int p = 0; p < 2; p++) begin
            wi = int'(a[p] >> 2);
            if (r[p] && w[p] && wi < MW)
                for (int k = 0; k < 4; k++)
                    if (b[p][k]) ref_mem[wi][8*k +: 8] = d[p][8*k +: 8];
        end
        @(posedge clk);
        @(negedge clk);
        chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, exp_rv[0]});
        chk("data_rvalid",  {31'b0, data_rvalid_o},  {31'b0, exp_rv[1]});
        chk("instr_rdata",  instr_rdata_o, exp_rd[0]);
        chk("data_rdata",   data_rdata_o,  exp_rd[1]);
    endtask

    task automatic mem_compare(input string tag);
        int nmis;
        nmis = 0;
        for (int i = 0; i < MW; i++)
            if (dut.mem_array[i] !== ref_mem[i]) nmis++;
        chk(tag, 32'(nmis), 32'h0);
    endtask

    initial begin
        logic [31:0] v, a;
        int widx;
        rst = 1'b1;
        idle();
        exp_rd[0] = '0; exp_rd[1] = '0; exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;

        // Preload while in reset; the mailbox word and the collision target get known values.
        for (int i = 0; i < MW; i++) begin
            v = $urandom;
            dut.mem_array[i] = v;
            ref_mem[i] = v;
        end
        dut.mem_array[32'h80] = 32'h0;      ref_mem[32'h80] = 32'h0;
        dut.mem_array[40704]  = 32'h1;      ref_mem[40704]  = 32'h1;

        @(posedge clk); @(negedge clk);
        chk("rst_instr_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
        chk("rst_data_rvalid",  {31'b0, data_rvalid_o},  32'h0);
        chk("rst_instr_rdata",  instr_rdata_o, 32'h0);
        chk("rst_data_rdata",   data_rdata_o,  32'h0);

        // Requests during reset are granted but never accepted.
        set_port(1, 1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D);
        #1 chk("rst_data_gnt", {31'b0, data_gnt_o}, 32'h1);
        @(posedge clk); @(negedge clk);
        chk("rst_no_rvalid", {31'b0, data_rvalid_o}, 32'h0);
        idle();
        rst = 1'b0;
        mem_compare("rst_mem_kept");

        // Mailbox read after reset release.
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0002_7C00, 32'h0);
        step(); idle();
        chk("mailbox", data_rdata_o, 32'h1);
        chk("mailbox_rvalid", {31'b0, data_rvalid_o}, 32'h1);

        // Full write on data, read back on instr.
        set_port(1, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        step();
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        step(); idle();
        chk("full_write", instr_rdata_o, 32'hDEAD_BEEF);

        // Partial write then read with partial be (full word returned).
        set_port(1, 1'b1, 1'b1, 4'b0101, 32'h100, 32'h1122_3344);
        step();
        chk("write_resp_prewrite", data_rdata_o, 32'hDEAD_BEEF);
        set_port(1, 1'b1, 1'b0, 4'b0010, 32'h101, 32'h0);
        step(); idle();
        chk("partial_write", data_rdata_o, 32'hDE22_BE44);

        // Read-first collision.
        set_port(1, 1'b1, 1'b1, 4'hF, 32'h200, 32'hA5A5_A5A5);
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        step();
        chk("read_first", instr_rdata_o, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(); idle();
        chk("after_collide", instr_rdata_o, 32'hA5A5_A5A5);

        // Both ports write the same word: data bytes win where enabled.
        set_port(0, 1'b1, 1'b1, 4'hF,    32'h300, 32'h1111_1111);
        set_port(1, 1'b1, 1'b1, 4'b1001, 32'h300, 32'h2222_2222);
        step();
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(); idle();
        chk("ww_collide", instr_rdata_o, 32'h2211_1122);

        // Out of range.
        set_port(1, 1'b1, 1'b0, 4'hF, 32'(4*MW), 32'h0);
        step();
        chk("oor_read", data_rdata_o, 32'h0);
        set_port(1, 1'b1, 1'b1, 4'hF, 32'(4*MW), 32'h5555_AAAA);
        step(); idle();
        mem_compare("oor_write");

        // Reset between acceptance and response: response discarded.
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle();
        #1;
        chk("mid_rst_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
        chk("mid_rst_rdata",  instr_rdata_o, 32'h0);
        @(negedge clk);
        chk("mid_rst_rvalid2", {31'b0, instr_rvalid_o}, 32'h0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0; exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        step();
        mem_compare("mid_rst_mem");

        // Random traffic over a small hot window to force collisions, plus some out-of-range hits.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                widx = ($urandom_range(0, 9) == 0) ? (MW + int'($urandom_range(0, 7))) : int'($urandom_range(0, 15));
                a = {widx[29:0], 2'(($urandom) & 3)};
                set_port(p, 1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), a, $urandom);
            end
            step();
        end
        idle();
        step();
        mem_compare("final_mem");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/obi_dual_port_ram.md
Name: obi_dual_port_ram

Overview:
- Simulation and FPGA-style shared memory behind two independent OBI slave ports.
- The instruction port serves the GPGPU fetch path; the data port serves the GPGPU load/store path.
- Both ports access one word-addressed array, `mem_array`. Testbenches preload this array hierarchically and poll a mailbox word in it to detect kernel completion.
- Default size is 160 KB: 32 KB instruction region plus 4 x 32 KB data regions.

Parameters:
- MEM_SIZE_WORD, 40960: number of 32-bit words in `mem_array`.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  instruction-port OBI request.
- instr_we_i  in  1  instruction-port write enable (1 = write).
- instr_be_i  in  4  instruction-port byte enables.
- instr_addr_i  in  32  instruction-port byte address.
- instr_wdata_i  in  32  instruction-port write data.
- instr_gnt_o  out  1  instruction-port grant.
- instr_rvalid_o  out  1  instruction-port response valid.
- instr_rdata_o  out  32  instruction-port read data.
- data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_gnt_o, data_rvalid_o, data_rdata_o: same directions, widths and meanings, for the data port.

Behaviour:
- Storage: `mem_array[0:MEM_SIZE_WORD-1]`, 32 bits per word. It is a plain unpacked array named exactly `mem_array`, so benches can use $readmemh and direct hierarchical reads/writes.
- Reset never clears `mem_array`. Contents written while rst_i is high (preload) are retained.
- Word index = addr[31:2]; addr[1:0] are ignored.
- Grant: gnt_o = req_i, combinationally, on each port. No wait states and no back-pressure.
- Acceptance: a request is accepted in any cycle with req_i=1 and rst_i=0.
- Response timing: exactly one cycle after acceptance, rvalid_o=1 for one cycle. This applies to reads and to writes.
  - Back-to-back requests give back-to-back rvalid pulses.
  - Responses stay in order; at most one response is outstanding per port.
- Read response: rdata_o is the word at the accepted index, sampled at the acceptance edge. It is registered and held stable until the next response.
- Write: for each byte b with be[b]=1, `mem_array[idx][8b+7:8b]` is updated at the acceptance edge. Bytes with be=0 are unchanged. The write response carries rdata_o = the pre-write word.
- Read with partial be: the full word is returned; be is ignored for reads.
- Out of range (idx >= MEM_SIZE_WORD):
  - writes are dropped;
  - reads return 32'h0;
  - the response still arrives normally, with rvalid one cycle later.
- Same-cycle collisions:
  - Read on one port and write to the same word on the other port: the read returns the old data (read-first).
  - Both ports write the same word: per byte, the data-port write wins wherever its be bit is set; the instruction-port bytes are applied elsewhere.
- Reset, asserted asynchronously:
  - rvalid_o=0 and rdata_o=32'h0 on both ports immediately;
  - any pending response is discarded;
  - gnt_o follows req_i;
  - requests presented during reset are not accepted.
- No internal arbitration between ports: both ports complete every cycle independently.

Test Plan:
1. Preload via $readmemh; during reset, hierarchically force mem_array[40704]=1 -> the value survives reset release and reads 1 on the data port at addr 0x00027C00, with rvalid one cycle after req.
2. Data write addr 0x100, wdata 0xDEADBEEF, be 4'b1111; then instr read addr 0x100 -> gnt same cycle, rvalid next cycle, instr_rdata=0xDEADBEEF.
3. Partial write be=4'b0101, wdata 0x11223344 onto 0xDEADBEEF -> subsequent read returns 0xDE22BE44.
4. Same cycle: data write 0xA5A5A5A5 to 0x200 while instr reads 0x200 (old 0) -> instr_rdata=0; the following read returns 0xA5A5A5A5.
5. Read addr 4*MEM_SIZE_WORD -> rvalid after one cycle, rdata=0. Write there -> no array word changes.
6. Assert rst_i in the cycle between an accepted read and its response -> rvalid never asserts; memory is unchanged.
